// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU:
// grants one operation at a time, registers its operands and captures the result.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [15:0] Src1_0,
  input  logic [15:0] Src1_1,
  input  logic [15:0] Src2_0,
  input  logic [15:0] Src2_1,
  input  logic [2:0]  Op0,
  input  logic [2:0]  Op1,
  input  logic [15:0] AluResult,
  input  logic        AluZero,
  output logic        Done0,
  output logic        Done1,
  output logic [15:0] AluSrc1,
  output logic [15:0] AluSrc2,
  output logic [2:0]  AluCtrl,
  output logic [15:0] Result,
  output logic        Zero,
  output logic        Busy
);

  // state | meaning
  // IDLE  | sampling requests, no operation in flight
  // EXEC  | operands on the ALU, result captured at the end of this cycle
  // DONE  | result valid, completion pulse to the owner
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        owner_q;
  logic        last_q;
  logic [15:0] alu_src1_q;
  logic [15:0] alu_src2_q;
  logic [2:0]  alu_ctrl_q;
  logic [15:0] result_q;
  logic        zero_q;

  logic        any_req;
  logic        winner_d;

  // With both requesting, the one that was not served last wins.
  always_comb begin
    any_req  = Req0 | Req1;
    winner_d = (Req0 && Req1) ? ~last_q : Req1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      alu_src1_q <= 16'h0000;
      alu_src2_q <= 16'h0000;
      alu_ctrl_q <= 3'b000;
      result_q   <= 16'h0000;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q    <= winner_d;
            alu_src1_q <= winner_d ? Src1_1 : Src1_0;
            alu_src2_q <= winner_d ? Src2_1 : Src2_0;
            alu_ctrl_q <= winner_d ? Op1 : Op0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          result_q <= AluResult;
          zero_q   <= AluZero;
          state_q  <= DONE;
        end
        DONE: begin
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Done0   = (state_q == DONE) && !owner_q;
  assign Done1   = (state_q == DONE) &&  owner_q;
  assign Busy    = (state_q != IDLE);
  assign AluSrc1 = alu_src1_q;
  assign AluSrc2 = alu_src2_q;
  assign AluCtrl = alu_ctrl_q;
  assign Result  = result_q;
  assign Zero    = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized requesters,
// checked against a timeline model of grants (edge numbers) and adder results.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1;
  logic [15:0] s1_0, s2_0, s1_1, s2_1;
  logic [2:0]  op0, op1;
  logic        done0, done1, busy, zero, alu_zero;
  logic [15:0] alu_src1, alu_src2, result, alu_result;
  logic [2:0]  alu_ctrl;

  assign alu_result = alu_src1 + alu_src2;
  assign alu_zero   = (alu_result == 16'h0000);

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .Req0(req0), .Req1(req1),
    .Src1_0(s1_0), .Src1_1(s1_1), .Src2_0(s2_0), .Src2_1(s2_1),
    .Op0(op0), .Op1(op1),
    .AluResult(alu_result), .AluZero(alu_zero),
    .Done0(done0), .Done1(done1),
    .AluSrc1(alu_src1), .AluSrc2(alu_src2), .AluCtrl(alu_ctrl),
    .Result(result), .Zero(zero), .Busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a grant at edge g occupies the ALU until edge g+3; Done shows in cycle g+1.
  int          edge_n, avail_edge, g_edge, g_owner, last_w;
  logic [15:0] e_a, e_b, e_res;
  logic [2:0]  e_op;
  logic        e_zero;

  int dl_cyc[$];
  int dl_who[$];

  bit auto_mode, keep0, keep1;

  function automatic void model_reset();
    edge_n = 0; avail_edge = 0; g_edge = -10; g_owner = 0; last_w = 1;
    e_a = '0; e_b = '0; e_op = '0; e_res = '0; e_zero = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [15:0] sum;
    edge_n++;
    if (edge_n == g_edge + 1) begin
      sum    = e_a + e_b;
      e_res  = sum;
      e_zero = (sum == 16'h0000);
    end
    if (edge_n == g_edge + 2) last_w = g_owner;
    if (edge_n >= avail_edge && (req0 || req1)) begin
      if (req0 && req1) g_owner = (last_w == 0) ? 1 : 0;
      else              g_owner = req0 ? 0 : 1;
      g_edge     = edge_n;
      avail_edge = edge_n + 3;
      e_a  = g_owner ? s1_1 : s1_0;
      e_b  = g_owner ? s2_1 : s2_0;
      e_op = g_owner ? op1  : op0;
    end
  endfunction

  task automatic check_cycle();
    bit in_done;
    in_done = (edge_n == g_edge + 1);
    chk("busy",    busy,  (edge_n == g_edge) || in_done);
    chk("done0",   done0, in_done && g_owner == 0);
    chk("done1",   done1, in_done && g_owner == 1);
    chk("done_excl", done0 & done1, 0);
    chk("alu_src1", alu_src1, e_a);
    chk("alu_src2", alu_src2, e_b);
    chk("alu_ctrl", alu_ctrl, e_op);
    chk("result",  result, e_res);
    chk("zero",    zero,   e_zero);
    if (done0) begin dl_cyc.push_back(edge_n); dl_who.push_back(0); end
    if (done1) begin dl_cyc.push_back(edge_n); dl_who.push_back(1); end
  endtask

  task automatic new_ops(output logic [15:0] a, output logic [15:0] b, output logic [2:0] op);
    a  = 16'($urandom);
    b  = ($urandom_range(7) == 0) ? 16'(-a) : 16'($urandom);
    op = 3'($urandom);
  endtask

  task automatic drive_reqs();
    bit k0, k1;
    k0 = auto_mode ? bit'($urandom_range(1)) : keep0;
    k1 = auto_mode ? bit'($urandom_range(1)) : keep1;
    if (req0 && done0) begin
      if (k0) new_ops(s1_0, s2_0, op0); else req0 = 1'b0;
    end else if (!req0 && auto_mode && $urandom_range(2) == 0) begin
      req0 = 1'b1; new_ops(s1_0, s2_0, op0);
    end
    if (req1 && done1) begin
      if (k1) new_ops(s1_1, s2_1, op1); else req1 = 1'b0;
    end else if (!req1 && auto_mode && $urandom_range(2) == 0) begin
      req1 = 1'b1; new_ops(s1_1, s2_1, op1);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_cycle();
      drive_reqs();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    auto_mode = 1'b0; keep0 = 1'b0; keep1 = 1'b0;
    @(negedge clk);
    model_reset();
    check_cycle();
    dl_cyc.delete(); dl_who.delete();
  endtask

  initial begin
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    s1_0 = '0; s2_0 = '0; s1_1 = '0; s2_1 = '0; op0 = '0; op1 = '0;

    // single requester 0
    do_reset();
    req0 = 1'b1; s1_0 = 16'hA607; s2_0 = 16'h581D; op0 = 3'b010;
    rst = 1'b1;
    run_cycles(1);
    chk("r030_src1", alu_src1, 16'hA607);
    chk("r030_ctrl", alu_ctrl, 3'b010);
    run_cycles(1);
    chk("r030_res",   result, 16'hFE24);
    chk("r030_zero",  zero,   1'b0);
    chk("r030_done0", done0,  1'b1);
    run_cycles(4);
    chk("r030_ndone", dl_cyc.size(), 1);

    // requester 1, result wraps to zero
    do_reset();
    req1 = 1'b1; s1_1 = 16'h0001; s2_1 = 16'hFFFF; op1 = 3'b001;
    rst = 1'b1;
    run_cycles(2);
    chk("r031_res",   result, 16'h0000);
    chk("r031_zero",  zero,   1'b1);
    chk("r031_done1", done1,  1'b1);
    run_cycles(4);
    chk("r031_ndone", dl_cyc.size(), 1);

    // both requesting from reset release
    do_reset();
    req0 = 1'b1; new_ops(s1_0, s2_0, op0);
    req1 = 1'b1; new_ops(s1_1, s2_1, op1);
    rst = 1'b1;
    run_cycles(8);
    chk("r032_ndone", dl_cyc.size(), 2);
    if (dl_cyc.size() == 2) begin
      chk("r032_first",  dl_who[0], 0);
      chk("r032_second", dl_who[1], 1);
      chk("r032_gap",    dl_cyc[1] - dl_cyc[0], 3);
    end

    // continuous reissue from both
    dl_cyc.delete(); dl_who.delete();
    keep0 = 1'b1; keep1 = 1'b1;
    req0 = 1'b1; new_ops(s1_0, s2_0, op0);
    req1 = 1'b1; new_ops(s1_1, s2_1, op1);
    run_cycles(24);
    keep0 = 1'b0; keep1 = 1'b0;
    run_cycles(8);
    chk("r033_ndone_ge8", dl_cyc.size() >= 8, 1);
    for (int i = 1; i < dl_cyc.size(); i++) begin
      chk("r033_alt", dl_who[i], (dl_who[i-1] == 0) ? 1 : 0);
      chk("r033_gap", dl_cyc[i] - dl_cyc[i-1], 3);
    end

    // reset asserted during EXEC of a requester-1 op
    do_reset();
    req1 = 1'b1; new_ops(s1_1, s2_1, op1);
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("r034_busy_rst", busy, 1'b0);
    check_cycle();
    req1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_cycles(5);
    chk("r034_no_done", dl_cyc.size(), 0);
    req1 = 1'b1; new_ops(s1_1, s2_1, op1);
    run_cycles(5);
    chk("r034_after", dl_cyc.size(), 1);

    // requester 0 keeps Req high through Done
    do_reset();
    keep0 = 1'b1;
    req0 = 1'b1; new_ops(s1_0, s2_0, op0);
    rst = 1'b1;
    run_cycles(6);
    keep0 = 1'b0;
    run_cycles(5);
    chk("r035_ndone", dl_cyc.size(), 3);
    if (dl_cyc.size() >= 2) begin
      chk("r035_who", dl_who[1], 0);
      chk("r035_gap", dl_cyc[1] - dl_cyc[0], 3);
    end

    // randomized traffic
    do_reset();
    rst = 1'b1;
    auto_mode = 1'b1;
    run_cycles(400);
    chk("rand_some_done", dl_cyc.size() > 20, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
